// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// bin2bcd_seq
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// It feeds the four digit inputs of the seven-segment display multiplexer.
// The output digits are registered. They update only when a conversion
// finishes, so the display never shows intermediate digits.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      conversion request, accepted only while ready
//   bin        unsigned binary input, sampled on the accepting edge
//   ready      high while idle and able to accept start
//   done_tick  one-cycle pulse; bcd3..bcd0 and ovf are new in this cycle
//   ovf        last accepted bin exceeded MAX_VAL (digits saturated to 9999)
//   bcd3..bcd0 thousands, hundreds, tens and ones digits
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ready=1
// OP    | one adjust+shift step per clock, BIN_W steps (n counts down)
// DONE  | single cycle: load output digits and ovf, pulse done_tick
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             done_tick,
  output logic             ovf,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0
);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  localparam logic [31:0] MAX_C = MAX_VAL;

  state_t           state_q, state_d;
  // The shift register is exactly BIN_W wide, so bin's MSB is the first bit
  // shifted into the BCD register. This holds for any BIN_W.
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [15:0]      work_q, work_d;
  logic [15:0]      adj;
  logic [3:0]       n_q, n_d;
  logic             sat_q, sat_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Add 3 to every working digit >= 5 before the shift. Each digit is a
  // 4-bit add, and no carry crosses into the neighbouring digit.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    n_d     = n_q;
    sat_d   = sat_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          work_d  = '0;
          n_d     = 4'(BIN_W);
          sat_d   = (32'(bin) > MAX_C);
          state_d = OP;
        end
      end
      OP: begin
        {work_d, shift_d} = {adj, shift_q} << 1;
        n_d = n_q - 4'd1;
        if (n_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        bcd_d   = sat_q ? 16'h9999 : work_q;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      n_q     <= '0;
      sat_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      n_q     <= n_d;
      sat_q   <= sat_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = done_q;
  assign ovf       = ovf_q;
  assign bcd3      = bcd_q[15:12];
  assign bcd2      = bcd_q[11:8];
  assign bcd1      = bcd_q[7:4];
  assign bcd0      = bcd_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
// Testbench for bin2bcd_seq: directed vectors with hand-computed BCD results.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        ready, done_tick, ovf;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;

  int n_vec = 0;
  int n_bad = 0;

  bin2bcd_seq #(.BIN_W(14), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .done_tick(done_tick), .ovf(ovf),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_tick) seen++;
    end
    chk("no_extra_done", seen, 0);
  endtask

  // Launch one conversion and wait for done_tick. Optionally pulse start
  // again with inj_v at cycle inj, which must be ignored.
  task automatic run(input logic [13:0] v, input logic [15:0] exp_bcd,
                     input logic exp_ovf, input int inj, input logic [13:0] inj_v);
    int          cyc = 0;
    int          rl = 0;
    logic        hold_bad = 1'b0;
    logic [16:0] prev;
    prev = {ovf, bcd3, bcd2, bcd1, bcd0};
    @(negedge clk);
    bin = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin = '0;
    while (!done_tick && cyc < 40) begin
      if (!ready) rl++;
      if ({ovf, bcd3, bcd2, bcd1, bcd0} !== prev) hold_bad = 1'b1;
      if (cyc == inj) begin
        start = 1'b1;
        bin = inj_v;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, 15);
    chk("ready_low_cycles", rl, 15);
    chk("hold", {31'd0, hold_bad}, 0);
    chk("bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, exp_bcd});
    chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done_tick}, 0);
    chk("ready_after", {31'd0, ready}, 1);
  endtask

  initial begin
    int cyc;
    // reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_ready", {31'd0, ready}, 1);
    quiet(5);

    // nominal, then a busy request that must not be queued
    run(14'd1234, 16'h1234, 1'b0, -1, '0);
    run(14'd5678, 16'h5678, 1'b0, 5, 14'd1111);
    quiet(20);

    // boundaries and the adjust-digit corner
    run(14'd0,    16'h0000, 1'b0, -1, '0);
    run(14'd9,    16'h0009, 1'b0, -1, '0);
    run(14'd9999, 16'h9999, 1'b0, -1, '0);
    run(14'd1009, 16'h1009, 1'b0, -1, '0);
    run(14'd8191, 16'h8191, 1'b0, -1, '0);

    // saturation
    run(14'd10000, 16'h9999, 1'b1, -1, '0);
    run(14'd42,    16'h0042, 1'b0, -1, '0);
    run(14'd16383, 16'h9999, 1'b1, -1, '0);

    // reset mid-operation, outputs were 9999/ovf before
    @(negedge clk);
    bin = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 0);
    chk("midrst_ovf", {31'd0, ovf}, 0);
    chk("midrst_done", {31'd0, done_tick}, 0);
    @(negedge clk);
    rst = 1'b0;
    quiet(20);
    chk("midrst_ready", {31'd0, ready}, 1);
    run(14'd4321, 16'h4321, 1'b0, -1, '0);

    // start arriving in the DONE cycle is ignored
    run(14'd42, 16'h0042, 1'b0, 14, 14'd777);
    quiet(20);

    // start held high retriggers every BIN_W+2 cycles
    @(negedge clk);
    bin = 14'd77;
    start = 1'b1;
    cyc = 0;
    while (!done_tick && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("retrig_first", cyc, 16);
    cyc = 0;
    @(negedge clk);
    cyc++;
    while (!done_tick && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("retrig_period", cyc, 16);
    chk("retrig_bcd", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'h0077);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("final_ready", {31'd0, ready}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
